divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/mul_div_pkg.sv | 26 ++
 rtl/div_step.sv | 26 ++
 rtl/divider.sv | 153 +++++++++++++++
 tb/tb_divider.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the multiply/divide units: FSM states, mode encodings
// and width-parameterised bit-pattern helpers.
package mul_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  localparam logic CTRL_UNSIGNED = 1'b0;
  localparam logic CTRL_SIGNED   = 1'b1;

  localparam int PAT_W = 64;

  // Most negative two's complement value of a w-bit word (only the MSB set).
  function automatic logic [PAT_W-1:0] min_neg_pat(input int w);
    return {{(PAT_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  // All-ones pattern of a w-bit word (-1 in two's complement).
  function automatic logic [PAT_W-1:0] neg_one_pat(input int w);
    return (w >= PAT_W) ? {PAT_W{1'b1}} : (({{(PAT_W-1){1'b0}}, 1'b1} << w) - 1'b1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if non-negative.
module div_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] rem_i,
  input  logic [n-1:0] qsh_i,
  input  logic [n-1:0] dvs_i,
  output logic [n-1:0] rem_o,
  output logic [n-1:0] qsh_o
);

  logic [n:0] trial;
  logic [n:0] diff;
  logic       q_bit;

  // The remainder is always below the divisor, so a set MSB of diff means borrow.
  always_comb begin
    trial = {rem_i, qsh_i[n-1]};
    diff  = trial - {1'b0, dvs_i};
    q_bit = ~diff[n];
    rem_o = q_bit ? diff[n-1:0] : trial[n-1:0];
    qsh_o = {qsh_i[n-2:0], q_bit};
  end

endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned divider: accept, n restoring steps, one sign-fix
// cycle; a zero divisor skips straight to the fix cycle.
module divider
  import mul_div_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         ctrl,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         div_by_zero
);

  typedef logic [n-1:0] word_t;

  localparam int            CW       = (n > 2) ? $clog2(n) : 1;
  localparam word_t         MIN_NEG  = word_t'(min_neg_pat(n));
  localparam word_t         NEG_ONE  = word_t'(neg_one_pat(n));
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  function automatic word_t neg_if(input word_t v, input logic s);
    return s ? word_t'(-v) : v;
  endfunction

  function automatic logic sign_of(input word_t v);
    return |(v & MIN_NEG);
  endfunction

  // |MIN_NEG| wraps to MIN_NEG itself, which is the correct n-bit unsigned magnitude.
  function automatic word_t mag(input word_t v, input logic signed_mode);
    return neg_if(v, signed_mode & sign_of(v));
  endfunction

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  word_t         q_q, q_d;
  word_t         r_q, r_d;
  logic          dbz_q, dbz_d;

  word_t         rem_q, rem_d;
  word_t         qsh_q, qsh_d;
  word_t         dvs_q, dvs_d;
  logic          sa_q, sa_d;
  logic          sq_q, sq_d;
  logic          mode_q, mode_d;

  word_t         rem_nx;
  word_t         qsh_nx;

  div_step #(.n(n)) u_step (
    .rem_i (rem_q),
    .qsh_i (qsh_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .qsh_o (qsh_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dvs_d   = dvs_q;
    sa_d    = sa_q;
    sq_d    = sq_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (B == '0) ? ST_FIX : ST_CALC;
          cnt_d   = '0;
          rem_d   = '0;
          // On a zero divisor the raw dividend is parked here to become R.
          qsh_d   = (B == '0) ? A : mag(A, ctrl);
          dvs_d   = mag(B, ctrl);
          sa_d    = sign_of(A);
          sq_d    = sign_of(A) ^ sign_of(B);
          mode_d  = ctrl;
        end
      end
      ST_CALC: begin
        rem_d = rem_nx;
        qsh_d = qsh_nx;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (dvs_q == '0) begin
          q_d   = NEG_ONE;
          r_d   = qsh_q;
          dbz_d = 1'b1;
        end else begin
          q_d   = neg_if(qsh_q, (mode_q == CTRL_SIGNED) & sq_q);
          r_d   = neg_if(rem_q, (mode_q == CTRL_SIGNED) & sa_q);
          dbz_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    qsh_q  <= qsh_d;
    dvs_q  <= dvs_d;
    sa_q   <= sa_d;
    sq_q   <= sq_d;
    mode_q <= mode_d;
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Directed and back-to-back random checks of the iterative divider at n=8.
module tb_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ctrl;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  divider #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .ctrl        (ctrl),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    A     = a;
    B     = b;
    ctrl  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done, and cycles with busy high.
  task automatic wait_done(output int edges, output int bc);
    edges = 0;
    bc    = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      edges++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic ez, input int elat);
    int edges;
    int bc;
    launch(a, b, c);
    wait_done(edges, bc);
    check({tag, "_q"},    {24'd0, Q}, {24'd0, eq});
    check({tag, "_r"},    {24'd0, R}, {24'd0, er});
    check({tag, "_dbz"},  {31'd0, div_by_zero}, {31'd0, ez});
    check({tag, "_lat"},  edges, elat);
    check({tag, "_busy"}, bc, elat);
  endtask

  initial begin
    int edges;
    int bc;
    logic [N-1:0] ra, rb, eq, er;
    logic         rc, ez;
    int           ai, bi;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    ctrl  = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q",    {24'd0, Q}, 32'd0);
    check("rst_r",    {24'd0, R}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);

    // Start is raised together with the reset release: first edge with rst=0 accepts.
    rst = 1'b0;
    do_op("u200_7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 9);
    tick();
    check("pulse_low", {31'd0, done}, 32'd0);
    check("hold_q",    {24'd0, Q}, 32'd28);
    tick();
    check("hold_r",    {24'd0, R}, 32'd4);

    do_op("s_m7_2",  8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9);
    do_op("s_min_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9);
    do_op("s_7_m2",  8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9);
    do_op("u_div0",  8'h35, 8'h00, 1'b0, 8'hFF, 8'h35, 1'b1, 1);
    do_op("s_div0",  8'h35, 8'h00, 1'b1, 8'hFF, 8'h35, 1'b1, 1);
    do_op("u9_3",    8'd9,  8'd3,  1'b0, 8'd3,  8'd0,  1'b0, 9);

    // Start pulsed mid-operation with other operands must not disturb the result.
    launch(8'd200, 8'd7, 1'b0);
    tick();
    tick();
    A     = 8'd1;
    B     = 8'd1;
    ctrl  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(edges, bc);
    check("ign_q",   {24'd0, Q}, 32'd28);
    check("ign_r",   {24'd0, R}, 32'd4);
    check("ign_lat", edges + 3, 32'd9);
    tick();

    // Abort: extra start at cycle 3, reset at cycle 4.
    launch(8'd200, 8'd7, 1'b0);
    tick();
    tick();
    A     = 8'd1;
    B     = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b1;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_q",    {24'd0, Q}, 32'd0);
    check("abort_r",    {24'd0, R}, 32'd0);
    check("abort_dbz",  {31'd0, div_by_zero}, 32'd0);
    A     = 8'd100;
    B     = 8'd10;
    ctrl  = 1'b0;
    start = 1'b1;
    tick();
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    check("rst_prio_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    do_op("u100_10", 8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 9);

    // Back-to-back random operations, each launched in the previous done cycle.
    for (int i = 0; i < 4000; i++) begin
      ra = N'($urandom);
      rb = (i % 16 == 0) ? '0 : N'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (rb == '0) begin
        eq = '1;
        er = ra;
        ez = 1'b1;
      end else begin
        ez = 1'b0;
        if (rc) begin
          ai = int'($signed(ra));
          bi = int'($signed(rb));
        end else begin
          ai = int'(ra);
          bi = int'(rb);
        end
        eq = N'(ai / bi);
        er = N'(ai % bi);
      end
      check("b2b_idle", {31'd0, busy}, 32'd0);
      launch(ra, rb, rc);
      wait_done(edges, bc);
      check("rnd_q",   {24'd0, Q}, {24'd0, eq});
      check("rnd_r",   {24'd0, R}, {24'd0, er});
      check("rnd_dbz", {31'd0, div_by_zero}, {31'd0, ez});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
